// File: rtl/stopwatch_display.sv
// Binary MM.SS to multiplexed 4-digit 7-segment driver with one BCD conversion per scan frame.
// Optional LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is zero.
module stopwatch_display #(
    parameter int REFRESH_DIV        = 50000,
    parameter int CATHODE_ACTIVE_LOW = 1,
    parameter int ANODE_ACTIVE_LOW   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] minutes,
    input  logic [6:0] seconds,
    output logic [3:0] anodes,
    output logic [6:0] segments,
    output logic       dp
);
    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic              CAT_LOW = (CATHODE_ACTIVE_LOW != 0);
    localparam logic              ANO_LOW = (ANODE_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    logic [CNT_W-1:0] refresh_cnt_reg;
    logic [1:0]       digit_idx_reg;
    state_t           state_reg, state_next;
    logic [6:0]       min_work_reg, min_work_next, sec_work_reg, sec_work_next;
    logic [3:0]       min_tens_reg, min_tens_next, sec_tens_reg, sec_tens_next;
    logic [3:0][3:0]  digit_reg, digit_next;
    logic [3:0]       anode_next;
    logic [6:0]       seg_on, seg_next;
    logic [3:0]       cur_digit;
    logic             capture;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'h3F;
            4'd1: decode = 7'h06;
            4'd2: decode = 7'h5B;
            4'd3: decode = 7'h4F;
            4'd4: decode = 7'h66;
            4'd5: decode = 7'h6D;
            4'd6: decode = 7'h7D;
            4'd7: decode = 7'h07;
            4'd8: decode = 7'h7F;
            4'd9: decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= 2'd0;
        end else if (refresh_cnt_reg == CNT_MAX) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= digit_idx_reg + 2'd1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + CNT_ONE;
        end
    end

    assign capture = (refresh_cnt_reg == '0) && (digit_idx_reg == 2'd0);

    // Both work registers shed one ten per cycle in parallel; the tens count follows.
    always_comb begin
        state_next    = state_reg;
        min_work_next = min_work_reg;
        sec_work_next = sec_work_reg;
        min_tens_next = min_tens_reg;
        sec_tens_next = sec_tens_reg;
        digit_next    = digit_reg;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    min_work_next = (minutes > 7'd99) ? 7'd99 : minutes;
                    sec_work_next = (seconds > 7'd99) ? 7'd99 : seconds;
                    min_tens_next = 4'd0;
                    sec_tens_next = 4'd0;
                    state_next    = CONV;
                end
            end
            CONV: begin
                if (min_work_reg >= 7'd10) begin
                    min_work_next = min_work_reg - 7'd10;
                    min_tens_next = min_tens_reg + 4'd1;
                end
                if (sec_work_reg >= 7'd10) begin
                    sec_work_next = sec_work_reg - 7'd10;
                    sec_tens_next = sec_tens_reg + 4'd1;
                end
                if ((min_work_next < 7'd10) && (sec_work_next < 7'd10))
                    state_next = DONE;
            end
            DONE: begin
                digit_next[0] = sec_work_reg[3:0];
                digit_next[1] = sec_tens_reg;
                digit_next[2] = min_work_reg[3:0];
                digit_next[3] = min_tens_reg;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            min_work_reg <= 7'd0;
            sec_work_reg <= 7'd0;
            min_tens_reg <= 4'd0;
            sec_tens_reg <= 4'd0;
            digit_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            min_work_reg <= min_work_next;
            sec_work_reg <= sec_work_next;
            min_tens_reg <= min_tens_next;
            sec_tens_reg <= sec_tens_next;
            digit_reg    <= digit_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            assign anode_next[gi] = (digit_idx_reg == 2'(gi)) ^ ANO_LOW;
        end
    endgenerate

    always_comb begin
        cur_digit = digit_reg[digit_idx_reg];
        seg_on    = decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_idx_reg == 2'd3) && (cur_digit == 4'd0))
            seg_on = 7'h00;
`endif
        seg_next = seg_on ^ {7{CAT_LOW}};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            anodes   <= {4{ANO_LOW}};
            segments <= {7{CAT_LOW}};
            dp       <= CAT_LOW;
        end else begin
            anodes   <= anode_next;
            segments <= seg_next;
            dp       <= (digit_idx_reg == 2'd2) ^ CAT_LOW;
        end
    end
endmodule
